// File: rtl/cmlk_timing_monitor.sv
// cmlk_timing_monitor: receive-side checker for the CMOS trigger, laser and
// gate pulse trains. Measures per-frame periods, widths, laser-to-gate delay
// and laser pulse count in the clk domain; one result set per CMOS frame.
// Optional build macro: CMLK_TIMING_MON_GLITCH_FILTER_EN (3-sample glitch
// filter on each synchronized pin, with a saturating glitch counter).
module cmlk_timing_monitor #(
  parameter int unsigned TIMEOUT_CYC = 100000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        clear_err,
  input  logic        cmos_trig_in,
  input  logic        laser_in,
  input  logic        gate_in,
  output logic        meas_valid,
  output logic [31:0] cmos_period,
  output logic [31:0] cmos_width,
  output logic [31:0] laser_period,
  output logic [31:0] laser_width,
  output logic [15:0] laser_count,
  output logic [31:0] gate_delay,
  output logic [31:0] gate_width,
  output logic        timeout_err,
  output logic [15:0] glitch_cnt
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MEASURE = 1'b1;

  // Pin index within the packed 3-bit pin vectors
  localparam int unsigned P_CMOS  = 0;
  localparam int unsigned P_LASER = 1;
  localparam int unsigned P_GATE  = 2;

  localparam logic [31:0] SAT32 = 32'hFFFF_FFFF;
  localparam logic [15:0] SAT16 = 16'hFFFF;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == SAT32) ? v : v + 32'd1;
  endfunction

  logic [2:0]  r_sync [SYNC_STAGES];
  logic [2:0]  w_raw;
  logic [2:0]  w_lvl;
  logic [2:0]  r_prev;
  logic [2:0]  w_rise;
  logic [2:0]  w_fall;

  logic [0:0]  r_state;
  logic [0:0]  w_state_nxt;
  logic        w_frame_edge;
  logic        w_publish;
  logic        w_timeout;

  logic [31:0] r_cmos_cnt;
  logic [31:0] r_wcnt [3];
  logic [31:0] r_wid  [3];
  logic [31:0] r_las_pcnt;
  logic [15:0] r_las_cnt;
  logic [31:0] r_las_per;
  logic [31:0] r_gate_dly;

  // Synchronizer chain, all three pins share identical depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 3'b000;
    end else begin
      r_sync[0] <= {gate_in, laser_in, cmos_trig_in};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_raw = r_sync[SYNC_STAGES-1];

`ifdef CMLK_TIMING_MON_GLITCH_FILTER_EN
  logic [2:0]  r_filt;
  logic [1:0]  r_run [3];
  logic [2:0]  w_glitch;
  logic [16:0] w_glitch_sum;

  // Filtered level flips on the third consecutive differing sample
  always_comb begin
    w_lvl    = r_filt;
    w_glitch = 3'b000;
    for (int p = 0; p < 3; p++) begin
      if (w_raw[p] != r_filt[p]) begin
        if (r_run[p] == 2'd2) w_lvl[p] = w_raw[p];
      end else if (r_run[p] != 2'd0) begin
        w_glitch[p] = 1'b1;
      end
    end
    w_glitch_sum = 17'(glitch_cnt) + 17'(w_glitch[0]) + 17'(w_glitch[1])
                 + 17'(w_glitch[2]);
  end

  // Filter state and saturating glitch counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filt     <= 3'b000;
      glitch_cnt <= 16'd0;
      for (int p = 0; p < 3; p++) r_run[p] <= 2'd0;
    end else begin
      r_filt <= w_lvl;
      for (int p = 0; p < 3; p++) begin
        if (w_raw[p] != r_filt[p] && r_run[p] != 2'd2) r_run[p] <= r_run[p] + 2'd1;
        else                                            r_run[p] <= 2'd0;
      end
      if (clear_err)           glitch_cnt <= 16'd0;
      else if (w_glitch_sum[16]) glitch_cnt <= SAT16;
      else                     glitch_cnt <= w_glitch_sum[15:0];
    end
  end
`else
  assign w_lvl      = w_raw;
  assign glitch_cnt = 16'd0;
`endif

  // Edge-detect register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= 3'b000;
    else     r_prev <= w_lvl;
  end

  assign w_rise = w_lvl & ~r_prev;
  assign w_fall = ~w_lvl & r_prev;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: frame edges, publish strobe, timeout and abort
  always_comb begin
    w_state_nxt  = r_state;
    w_frame_edge = 1'b0;
    w_publish    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable && w_rise[P_CMOS]) begin
          w_state_nxt  = ST_MEASURE;
          w_frame_edge = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (!enable) begin
          w_state_nxt = ST_IDLE;
        end else if (w_rise[P_CMOS]) begin
          w_frame_edge = 1'b1;
          w_publish    = 1'b1;
        end else if (r_cmos_cnt >= 32'(TIMEOUT_CYC)) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Width counters run on pin level; a width is committed on the falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 3; p++) begin
        r_wcnt[p] <= 32'd0;
        r_wid[p]  <= 32'd0;
      end
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (w_rise[p])     r_wcnt[p] <= 32'd1;
        else if (w_lvl[p]) r_wcnt[p] <= sat_inc32(r_wcnt[p]);
        if (w_fall[p])     r_wid[p]  <= r_wcnt[p];
      end
    end
  end

  // Frame counters; the edge cycle counts as 1 and coincident laser rises
  // belong to the new frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmos_cnt <= 32'd0;
      r_las_pcnt <= 32'd0;
      r_las_cnt  <= 16'd0;
      r_las_per  <= 32'd0;
      r_gate_dly <= 32'd0;
    end else begin
      r_cmos_cnt <= w_frame_edge ? 32'd1 : sat_inc32(r_cmos_cnt);
      r_las_pcnt <= w_rise[P_LASER] ? 32'd1 : sat_inc32(r_las_pcnt);
      if (w_frame_edge) begin
        r_las_cnt  <= w_rise[P_LASER] ? 16'd1 : 16'd0;
        r_las_per  <= 32'd0;
        r_gate_dly <= (w_rise[P_GATE] && w_rise[P_LASER]) ? 32'd0 : SAT32;
      end else begin
        if (w_rise[P_LASER] && r_las_cnt != SAT16) r_las_cnt <= r_las_cnt + 16'd1;
        if (w_rise[P_LASER] && r_las_cnt != 16'd0) r_las_per <= r_las_pcnt;
        if (w_rise[P_GATE]) begin
          if (w_rise[P_LASER])        r_gate_dly <= 32'd0;
          else if (r_las_cnt != 16'd0) r_gate_dly <= r_las_pcnt;
        end
      end
    end
  end

  // Result registers, strobe and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meas_valid   <= 1'b0;
      cmos_period  <= 32'd0;
      cmos_width   <= 32'd0;
      laser_period <= 32'd0;
      laser_width  <= 32'd0;
      laser_count  <= 16'd0;
      gate_delay   <= 32'd0;
      gate_width   <= 32'd0;
      timeout_err  <= 1'b0;
    end else begin
      meas_valid <= w_publish;
      if (w_publish) begin
        cmos_period  <= r_cmos_cnt;
        cmos_width   <= r_wid[P_CMOS];
        laser_period <= r_las_per;
        laser_width  <= r_wid[P_LASER];
        laser_count  <= r_las_cnt;
        gate_delay   <= r_gate_dly;
        gate_width   <= r_wid[P_GATE];
      end
      if (w_timeout)      timeout_err <= 1'b1;
      else if (clear_err) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cmlk_timing_monitor.sv
// tb_cmlk_timing_monitor: directed frame-level stimulus for cmlk_timing_monitor
// with hand-computed expected results.
module tb_cmlk_timing_monitor;

  localparam int MODE_NOMINAL = 0;
  localparam int MODE_COINC   = 1;
  localparam int MODE_GATE    = 2;
  localparam int MODE_GLITCH  = 3;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        clear_err;
  logic        cmos_trig_in;
  logic        laser_in;
  logic        gate_in;
  logic        meas_valid;
  logic [31:0] cmos_period;
  logic [31:0] cmos_width;
  logic [31:0] laser_period;
  logic [31:0] laser_width;
  logic [15:0] laser_count;
  logic [31:0] gate_delay;
  logic [31:0] gate_width;
  logic        timeout_err;
  logic [15:0] glitch_cnt;

  int n_checks;
  int n_pass;
  int valid_cnt;

  logic [31:0] s_cmos_period, s_cmos_width, s_laser_period, s_laser_width;
  logic [31:0] s_laser_count, s_gate_delay, s_gate_width;

  cmlk_timing_monitor #(
    .TIMEOUT_CYC (2000),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .clear_err    (clear_err),
    .cmos_trig_in (cmos_trig_in),
    .laser_in     (laser_in),
    .gate_in      (gate_in),
    .meas_valid   (meas_valid),
    .cmos_period  (cmos_period),
    .cmos_width   (cmos_width),
    .laser_period (laser_period),
    .laser_width  (laser_width),
    .laser_count  (laser_count),
    .gate_delay   (gate_delay),
    .gate_width   (gate_width),
    .timeout_err  (timeout_err),
    .glitch_cnt   (glitch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobe cycles and snapshot the published results
  always @(negedge clk) begin
    if (meas_valid) begin
      valid_cnt      <= valid_cnt + 1;
      s_cmos_period  <= cmos_period;
      s_cmos_width   <= cmos_width;
      s_laser_period <= laser_period;
      s_laser_width  <= laser_width;
      s_laser_count  <= 32'(laser_count);
      s_gate_delay   <= gate_delay;
      s_gate_width   <= gate_width;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  // Pin levels {gate, laser, cmos} at cycle c of a 1000-cycle frame
  function automatic logic [2:0] pins(input int mode, input int c);
    logic cm, la, ga;
    cm = (c < 100);
    la = 1'b0;
    ga = 1'b0;
    if (mode == MODE_NOMINAL || mode == MODE_GLITCH) begin
      if (c >= 20 && (c - 20) / 50 < 20 && (c - 20) % 50 < 5) la = 1'b1;
      if (c >= 30 && (c - 30) / 50 < 20 && (c - 30) % 50 < 8) ga = 1'b1;
      if (mode == MODE_GLITCH && (c == 45 || c == 60 || c == 61)) la = 1'b1;
    end else if (mode == MODE_COINC) begin
      la = (c >= 200 && c < 205);
      ga = (c >= 200 && c < 208);
    end else if (mode == MODE_GATE) begin
      ga = (c >= 200 && c < 208);
    end
    return {ga, la, cm};
  endfunction

  task automatic run_frame(input int mode, input int abort_at);
    valid_cnt = 0;
    for (int c = 0; c < 1000; c++) begin
      {gate_in, laser_in, cmos_trig_in} = pins(mode, c);
      if (c == abort_at) enable = 1'b0;
      if (abort_at >= 0 && c == abort_at + 10) enable = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_nominal(input string pfx);
    chk({pfx, "_cmos_period"},  s_cmos_period,  32'd1000);
    chk({pfx, "_cmos_width"},   s_cmos_width,   32'd100);
    chk({pfx, "_laser_period"}, s_laser_period, 32'd50);
    chk({pfx, "_laser_width"},  s_laser_width,  32'd5);
    chk({pfx, "_laser_count"},  s_laser_count,  32'd20);
    chk({pfx, "_gate_delay"},   s_gate_delay,   32'd10);
    chk({pfx, "_gate_width"},   s_gate_width,   32'd8);
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    valid_cnt = 0;
    rst = 1'b1;
    enable = 1'b0;
    clear_err = 1'b0;
    cmos_trig_in = 1'b0;
    laser_in = 1'b0;
    gate_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_meas_valid",  32'(meas_valid),  32'd0);
    chk("rst_cmos_period", cmos_period,      32'd0);
    chk("rst_laser_count", 32'(laser_count), 32'd0);
    chk("rst_gate_delay",  gate_delay,       32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_glitch_cnt",  32'(glitch_cnt),  32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    enable = 1'b1;

    // First edge from IDLE gives no result; the second publishes frame 1
    run_frame(MODE_NOMINAL, -1);
    chk("first_edge_no_valid", 32'(valid_cnt), 32'd0);
    run_frame(MODE_NOMINAL, -1);
    chk("nom_valid_once", 32'(valid_cnt), 32'd1);
    chk_nominal("nom");

    // Coincident laser/gate rise, single laser pulse
    run_frame(MODE_COINC, -1);
    run_frame(MODE_GATE, -1);
    chk("coinc_gate_delay",   s_gate_delay,   32'd0);
    chk("coinc_laser_period", s_laser_period, 32'd0);
    chk("coinc_laser_count",  s_laser_count,  32'd1);

    // Gate with no preceding laser rise; laser width holds the old commit
    run_frame(MODE_NOMINAL, -1);
    chk("nolaser_gate_delay",   s_gate_delay,   32'hFFFF_FFFF);
    chk("nolaser_laser_count",  s_laser_count,  32'd0);
    chk("nolaser_laser_period", s_laser_period, 32'd0);
    chk("nolaser_laser_width",  s_laser_width,  32'd5);
    chk("nolaser_gate_width",   s_gate_width,   32'd8);

    // Mid-frame abort: outputs hold, two rises needed for the next result
    run_frame(MODE_NOMINAL, 500);
    run_frame(MODE_NOMINAL, -1);
    chk("abort_no_valid",    32'(valid_cnt),  32'd0);
    chk("abort_hold_period", cmos_period,     32'd1000);
    chk("abort_hold_count",  32'(laser_count), 32'd20);
    run_frame(MODE_NOMINAL, -1);
    chk("abort_valid", 32'(valid_cnt), 32'd1);
    chk_nominal("abort");

    // Timeout: one CMOS pulse then silence
    for (int c = 0; c < 2500; c++) begin
      {gate_in, laser_in, cmos_trig_in} = {2'b00, c < 100};
      if (c == 10) valid_cnt = 0;
      if (c == 1990) chk("timeout_not_yet", 32'(timeout_err), 32'd0);
      if (c == 2020) chk("timeout_set",     32'(timeout_err), 32'd1);
      @(posedge clk);
      #1;
    end
    chk("timeout_no_valid", 32'(valid_cnt), 32'd0);
    run_frame(MODE_NOMINAL, -1);
    chk("restart_first_no_valid", 32'(valid_cnt),  32'd0);
    chk("timeout_sticky",         32'(timeout_err), 32'd1);
    run_frame(MODE_NOMINAL, -1);
    chk("restart_valid",       32'(valid_cnt), 32'd1);
    chk("restart_cmos_period", s_cmos_period,  32'd1000);
    clear_err = 1'b1;
    @(posedge clk);
    #1;
    clear_err = 1'b0;
    @(posedge clk);
    #1;
    chk("clear_err", 32'(timeout_err), 32'd0);

`ifdef CMLK_TIMING_MON_GLITCH_FILTER_EN
    run_frame(MODE_GLITCH, -1);
    run_frame(MODE_NOMINAL, -1);
    chk("glitch_laser_count", s_laser_count,     32'd20);
    chk("glitch_cnt",         32'(glitch_cnt),   32'd2);
`else
    chk("glitch_cnt_tied", 32'(glitch_cnt), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cmlk_timing_monitor.md
Name: cmlk_timing_monitor

Overview:
- Receive-side checker for the CMOS trigger, laser and gate pulse trains produced by the timing generator. Used for loop-back on the board and for field diagnostics.
- Samples the three pins in the 100 MHz domain and measures periods, widths, laser-to-gate delay and laser pulse count per CMOS frame.
- Publishes one result set per frame with a single-cycle valid strobe for register readback. Resolution is one clk cycle; serializer sub-cycle placement is not resolved.

Parameters:
- TIMEOUT_CYC, 100000000, cycles without a CMOS rising edge before timeout_err is raised (1 s at 100 MHz).
- SYNC_STAGES, 2, synchronizer flops per input pin; minimum 2.

Ports:
- clk  in  1  100 MHz measurement clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  measurement enable; low forces IDLE and no result updates
- clear_err  in  1  single-cycle pulse; clears timeout_err and glitch_cnt
- cmos_trig_in  in  1  CMOS trigger pin, asynchronous
- laser_in  in  1  laser pulse pin, asynchronous
- gate_in  in  1  gate pulse pin, asynchronous
- meas_valid  out  1  one-cycle strobe; result outputs updated in this cycle
- cmos_period  out  32  cycles between the last two CMOS rising edges
- cmos_width  out  32  CMOS high time, in cycles
- laser_period  out  32  cycles between the last two laser rising edges in the frame
- laser_width  out  32  high time of the last completed laser pulse in the frame
- laser_count  out  16  laser rising edges in the frame
- gate_delay  out  32  cycles from the most recent laser rise to the following gate rise
- gate_width  out  32  high time of the last completed gate pulse in the frame
- timeout_err  out  1  sticky timeout flag
- glitch_cnt  out  16  suppressed glitches; tied to 0 when the optional feature is absent

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0.
- Input path: SYNC_STAGES flops per pin, then an edge-detect register. Pin-to-edge latency is identical for all three inputs, so relative measurements are exact.
- State IDLE → MEASURE on a CMOS rising edge while enable=1. That first edge produces no meas_valid.
- In MEASURE, a CMOS rising edge does the following in the same cycle:
  - latch all running values into the outputs;
  - pulse meas_valid;
  - restart all frame counters, with the edge cycle counted as 1.
- Running counters:
  - 32-bit counters saturate at 0xFFFFFFFF.
  - laser_count saturates at 0xFFFF.
  - Width counters count cycles while the synchronized input is high. A width is committed on the falling edge.
- Width still open at a frame edge: the previously committed value is reported.
- laser_period: 0 if fewer than 2 laser rises occurred in the frame.
- gate_delay: 0xFFFFFFFF if no laser rise preceded a gate rise in the frame.
- Simultaneous edges:
  - laser rise and gate rise in the same cycle → gate_delay = 0;
  - laser rise coincident with a CMOS rise → counted in the new frame;
  - CMOS fall coincident with a CMOS rise is impossible (single pin).
- Timeout: the cmos period counter reaching TIMEOUT_CYC sets timeout_err and returns to IDLE without meas_valid. The next CMOS rise restarts measurement.
- timeout_err persists until clear_err or rst. If clear_err coincides with a new timeout, the set wins.
- enable=0 while in MEASURE: abort to IDLE the next cycle. Outputs hold their last values and no meas_valid is issued.
- rst mid-frame: immediate return to reset values.

Optional Feature:
- Macro: CMLK_TIMING_MON_GLITCH_FILTER_EN.
- Defined: each synchronized input passes through a 3-sample stability filter. The filtered level changes only after 3 consecutive equal samples. This adds a fixed 2-cycle latency to both edges, so widths and periods are unchanged. Pulses or gaps of 1–2 cycles are suppressed, and each one increments glitch_cnt (saturating at 0xFFFF, cleared by clear_err).
- Undefined: no filter, glitch_cnt constant 0, latency as described in Behaviour.

Test Plan:
- Bench setup: enable=1 unless stated.
- Nominal frame: CMOS period 1000 / width 100; laser period 50 / width 5, 20 pulses; gate 10 cycles after each laser rise, width 8 → second frame gives cmos_period=1000, cmos_width=100, laser_period=50, laser_width=5, laser_count=20, gate_delay=10, gate_width=8, meas_valid high for exactly 1 cycle.
- First-edge rule: enable asserted, then the first CMOS rise → no meas_valid; meas_valid on the second rise only.
- Coincident laser/gate rise, with a single laser pulse per frame → gate_delay=0, laser_period=0, laser_count=1.
- Timeout, TIMEOUT_CYC overridden to 2000: stop CMOS after one edge → timeout_err=1 at cycle 2000, no meas_valid. Restart with period 1000: first new edge gives no valid, second gives meas_valid. clear_err → timeout_err=0.
- Mid-frame abort: enable=0 at cycle 500 of a frame, then enable=1 → outputs unchanged, next valid result only after two CMOS rises.
- With CMLK_TIMING_MON_GLITCH_FILTER_EN: inject a 1-cycle and a 2-cycle laser pulse inside the nominal frame → laser_count=20, glitch_cnt=2. A 3-cycle pulse is counted (laser_count=21).
